// File: rtl/fft_frame_writer.sv
// Purpose : write side of the four FFT RAMs; stores one 1024-bin, 4-channel frame
//           at address = bin index and tracks the channel-1 peak inside [MINBIN, MAXBIN].
// Latency : accepted bin -> wren/wraddress/dataK one cycle later; maxbin/detectdone
//           two cycles after the eop bin.
// Backpressure: none on the input stream; while the RAMs are held for weightblock,
//           new frames are dropped and counted instead of stalled.
// Ports   : clk/reset (sync, active-high); fft_valid/fft_sop/fft_eop/fft_in1..4 input
//           stream; wb_done release pulse; wren/wraddress/data1..4 RAM write port;
//           maxbin/detectdone peak report; busy, frame_err, drop_cnt status.
module fft_frame_writer #(
  parameter int NPOINT     = 1024,
  parameter int MINBIN     = 4,
  parameter int MAXBIN     = 200,
  parameter int MAG_THRESH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fft_valid,
  input  logic        fft_sop,
  input  logic        fft_eop,
  input  logic [27:0] fft_in1,
  input  logic [27:0] fft_in2,
  input  logic [27:0] fft_in3,
  input  logic [27:0] fft_in4,
  input  logic        wb_done,
  output logic        wren,
  output logic [9:0]  wraddress,
  output logic [27:0] data1,
  output logic [27:0] data2,
  output logic [27:0] data3,
  output logic [27:0] data4,
  output logic [9:0]  maxbin,
  output logic        detectdone,
  output logic        busy,
  output logic        frame_err,
  output logic [7:0]  drop_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_REPORT, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [14:0] peak_mag_q, peak_mag_d;
  logic [9:0]  peak_bin_q, peak_bin_d;
  logic        wren_q, wren_d;
  logic [9:0]  wraddress_q, wraddress_d;
  logic [27:0] data1_q, data1_d, data2_q, data2_d, data3_q, data3_d, data4_q, data4_d;
  logic [9:0]  maxbin_q, maxbin_d;
  logic        detectdone_q, detectdone_d;
  logic        busy_q, busy_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;

  logic        accept;
  logic        drop_inc;
  logic [9:0]  idx;
  logic        is_last;
  logic        in_win;
  logic [14:0] cur_mag;
  logic [14:0] base_mag;
  logic [9:0]  base_bin;

  // |re| + |im| of a packed sample; |-8192| = 8192 fits the 14-bit unsigned result.
  function automatic logic [14:0] mag_of(input logic [27:0] s);
    logic [13:0] re_abs;
    logic [13:0] im_abs;
    re_abs = s[27] ? (~s[27:14] + 14'd1) : s[27:14];
    im_abs = s[13] ? (~s[13:0] + 14'd1) : s[13:0];
    return {1'b0, re_abs} + {1'b0, im_abs};
  endfunction

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    peak_mag_d   = peak_mag_q;
    peak_bin_d   = peak_bin_q;
    wren_d       = 1'b0;
    wraddress_d  = wraddress_q;
    data1_d      = data1_q;
    data2_d      = data2_q;
    data3_d      = data3_q;
    data4_d      = data4_q;
    maxbin_d     = maxbin_q;
    detectdone_d = 1'b0;
    frame_err_d  = 1'b0;
    drop_inc     = 1'b0;

    accept   = fft_valid && ((state_q == S_IDLE && fft_sop) || state_q == S_WRITE);
    // A sop always lands at bin 0, including a premature sop that restarts the frame.
    idx      = fft_sop ? 10'd0 : cnt_q;
    is_last  = (idx == 10'(NPOINT - 1));
    in_win   = (idx >= 10'(MINBIN)) && (idx <= 10'(MAXBIN));
    cur_mag  = mag_of(fft_in1);
    base_mag = fft_sop ? 15'd0 : peak_mag_q;
    base_bin = fft_sop ? 10'd0 : peak_bin_q;

    case (state_q)
      S_IDLE, S_WRITE: begin
        if (accept) begin
          wren_d      = 1'b1;
          wraddress_d = idx;
          data1_d     = fft_in1;
          data2_d     = fft_in2;
          data3_d     = fft_in3;
          data4_d     = fft_in4;
          cnt_d       = idx + 10'd1;
          peak_mag_d  = base_mag;
          peak_bin_d  = base_bin;
          // Strict compare: on a tie the earlier (lower) bin is kept.
          if (in_win && cur_mag > base_mag) begin
            peak_mag_d = cur_mag;
            peak_bin_d = idx;
          end
          if (fft_eop != is_last) begin
            // eop on the wrong bin, or the last bin arrived without eop (overrun).
            frame_err_d = 1'b1;
            drop_inc    = 1'b1;
            state_d     = S_IDLE;
          end else if (state_q == S_WRITE && fft_sop) begin
            frame_err_d = 1'b1;
            drop_inc    = 1'b1;
            state_d     = S_WRITE;
          end else if (fft_eop) begin
            state_d = S_REPORT;
          end else begin
            state_d = S_WRITE;
          end
        end
      end
      S_REPORT: begin
        if (peak_mag_q >= 15'(MAG_THRESH)) begin
          maxbin_d     = peak_bin_q;
          detectdone_d = 1'b1;
          state_d      = S_HOLD;
        end else begin
          drop_inc = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_HOLD: begin
        // RAMs stay frozen; each new sop is one lost frame, its other bins are ignored.
        if (fft_valid && fft_sop) drop_inc = 1'b1;
        if (wb_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    drop_cnt_d = (drop_inc && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      peak_mag_q   <= '0;
      peak_bin_q   <= '0;
      wren_q       <= 1'b0;
      wraddress_q  <= '0;
      data1_q      <= '0;
      data2_q      <= '0;
      data3_q      <= '0;
      data4_q      <= '0;
      maxbin_q     <= '0;
      detectdone_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      peak_mag_q   <= peak_mag_d;
      peak_bin_q   <= peak_bin_d;
      wren_q       <= wren_d;
      wraddress_q  <= wraddress_d;
      data1_q      <= data1_d;
      data2_q      <= data2_d;
      data3_q      <= data3_d;
      data4_q      <= data4_d;
      maxbin_q     <= maxbin_d;
      detectdone_q <= detectdone_d;
      busy_q       <= busy_d;
      frame_err_q  <= frame_err_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign wren       = wren_q;
  assign wraddress  = wraddress_q;
  assign data1      = data1_q;
  assign data2      = data2_q;
  assign data3      = data3_q;
  assign data4      = data4_q;
  assign maxbin     = maxbin_q;
  assign detectdone = detectdone_q;
  assign busy       = busy_q;
  assign frame_err  = frame_err_q;
  assign drop_cnt   = drop_cnt_q;

endmodule
